// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master engine between NUM_REQ clients.
// Sequences chip select, start pulse and completion, and enforces a CS gap and a watchdog.
module spi_master_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned data_width = 8,
    parameter int unsigned CS_GAP     = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*data_width-1:0]   req_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            err,
    output logic [data_width-1:0]           rdata,
    output logic                            busy,
    output logic [NUM_REQ-1:0]              cs_n,
    output logic                            start_master,
    output logic [data_width-1:0]           data_master_in,
    input  logic                            finish_master,
    input  logic [data_width-1:0]           data_master_out
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned WCNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned GCNT_W    = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;
    localparam int unsigned WAIT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    // The IDLE cycle that follows GAP is itself one of the CS_GAP deselected cycles.
    localparam int unsigned GAP_LAST  = (CS_GAP >= 2) ? CS_GAP - 2 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_DONE,
        ST_GAP
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [GCNT_W-1:0]       gcnt_q, gcnt_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [NUM_REQ-1:0]      cs_n_q, cs_n_d;
    logic                    err_q, err_d;
    logic                    busy_q;
    logic                    start_q, start_d;
    logic [data_width-1:0]   rdata_q, rdata_d;
    logic [data_width-1:0]   dmi_q, dmi_d;
    logic                    fin_prev_q;

    logic                    fin_edge;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;
    logic [data_width-1:0]   sel_word;
    logic [NUM_REQ-1:0]      sel_oh;
    logic [NUM_REQ-1:0]      idx_oh;

    assign fin_edge = finish_master & ~fin_prev_q;
    assign sel_oh   = NUM_REQ'(1) << sel_idx;
    assign idx_oh   = NUM_REQ'(1) << idx_q;

    // Round-robin pick: first asserted request after the pointer, with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_word  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!sel_found && req[IDX_W'((32'(ptr_q) + k) % NUM_REQ)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_word = req_data[i*data_width +: data_width];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        grant_d = grant_q;
        cs_n_d  = cs_n_q;
        done_d  = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        rdata_d = rdata_q;
        dmi_d   = dmi_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_SETUP;
                    idx_d   = sel_idx;
                    ptr_d   = sel_idx;
                    dmi_d   = sel_word;
                    grant_d = sel_oh;
                    cs_n_d  = ~sel_oh;
                end
            end
            ST_SETUP: begin
                state_d = ST_START;
                start_d = 1'b1;
            end
            ST_START: begin
                state_d = ST_WAIT;
                wcnt_d  = '0;
            end
            ST_WAIT: begin
                if (fin_edge) begin
                    state_d = ST_DONE;
                    rdata_d = data_master_out;
                    done_d  = idx_oh;
                end else if ((TIMEOUT != 0) && (wcnt_q == WCNT_W'(WAIT_LAST))) begin
                    state_d = ST_DONE;
                    done_d  = idx_oh;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end
            ST_DONE: begin
                grant_d = '0;
                cs_n_d  = '1;
                gcnt_d  = '0;
                state_d = (CS_GAP >= 2) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gcnt_q == GCNT_W'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d  = gcnt_q + GCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cs_n_d  = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            wcnt_q     <= '0;
            gcnt_q     <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            cs_n_q     <= '1;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            rdata_q    <= '0;
            dmi_q      <= '0;
            fin_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            wcnt_q     <= wcnt_d;
            gcnt_q     <= gcnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            cs_n_q     <= cs_n_d;
            err_q      <= err_d;
            busy_q     <= (state_d != ST_IDLE);
            start_q    <= start_d;
            rdata_q    <= rdata_d;
            dmi_q      <= dmi_d;
            fin_prev_q <= finish_master;
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign cs_n           = cs_n_q;
    assign start_master   = start_q;
    assign data_master_in = dmi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: arbitration order, CS timing,
// watchdog abort, stuck-high finish line and mid-transfer reset.
module tb_spi_master_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [NR-1:0]   cs_n;
    logic            start_master;
    logic [DW-1:0]   data_master_in;
    logic            finish_master;
    logic [DW-1:0]   data_master_out;

    int n_run  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    spi_master_arbiter #(
        .NUM_REQ    (NR),
        .data_width (DW),
        .CS_GAP     (2),
        .TIMEOUT    (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .grant           (grant),
        .done            (done),
        .err             (err),
        .rdata           (rdata),
        .busy            (busy),
        .cs_n            (cs_n),
        .start_master    (start_master),
        .data_master_in  (data_master_in),
        .finish_master   (finish_master),
        .data_master_out (data_master_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req           = '0;
        finish_master = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_cs_n", 32'(cs_n), 32'(4'hF));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_start", 32'(start_master), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 30) begin
            tick();
            n++;
        end
        check("grant_wait", 32'(grant != '0), 32'(1));
    endtask

    // Full transaction: grant visible, start next cycle, finish after lat cycles, release.
    task automatic serve(input logic [NR-1:0] exp_g, input logic [DW-1:0] exp_tx,
                         input logic [DW-1:0] rx, input int lat);
        logic [NR-1:0] exp_cs;
        exp_cs = ~exp_g;
        wait_grant();
        check("grant", 32'(grant), 32'(exp_g));
        check("cs_n_setup", 32'(cs_n), 32'(exp_cs));
        check("busy_setup", 32'(busy), 32'(1));
        check("tx_word", 32'(data_master_in), 32'(exp_tx));
        tick();
        check("start_pulse", 32'(start_master), 32'(1));
        for (int i = 0; i < lat; i++) begin
            tick();
            check("start_once", 32'(start_master), 32'(0));
        end
        finish_master   = 1'b1;
        data_master_out = rx;
        tick();
        check("done", 32'(done), 32'(exp_g));
        check("err_clear", 32'(err), 32'(0));
        check("rdata", 32'(rdata), 32'(rx));
        check("cs_n_done", 32'(cs_n), 32'(exp_cs));
        finish_master = 1'b0;
        tick();
        check("cs_release", 32'(cs_n), 32'(4'hF));
        check("grant_release", 32'(grant), 32'(0));
        check("done_pulse", 32'(done), 32'(0));
    endtask

    // Mutual exclusion of chip selects while clients contend.
    always @(negedge clk) begin
        if (mon_en) begin
            check("cs_onecold", 32'($countones(~cs_n) <= 1), 32'(1));
            if (grant != '0) begin
                check("busy_with_grant", 32'(busy), 32'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int gap;
        rst             = 1'b1;
        req             = '0;
        req_data        = '0;
        finish_master   = 1'b0;
        data_master_out = '0;

        // Single client with loopback word
        do_reset();
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_tx", 32'(data_master_in), 32'(0));
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        req      = 4'b0100;
        tick();
        check("t1_cs_n", 32'(cs_n), 32'(4'b1011));
        serve(4'b0100, 8'hA5, 8'h3C, 2);
        req = '0;

        // Two simultaneous requests and the CS gap between them
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b0011;
        serve(4'b0001, 8'h11, 8'h55, 1);
        req = 4'b0010;
        gap = 0;
        n   = 0;
        while (cs_n == 4'hF && n < 20) begin
            gap++;
            n++;
            tick();
        end
        check("cs_gap_len", 32'(gap), 32'(2));
        serve(4'b0010, 8'h22, 8'h66, 1);
        req = '0;

        // All clients requesting: rotation 0,1,2,3,0,1,2,3
        do_reset();
        mon_en = 1'b1;
        req    = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [NR-1:0] g;
            logic [DW-1:0] tx;
            logic [DW-1:0] rx;
            g  = NR'(1) << (k % 4);
            tx = DW'(8'h11 * ((k % 4) + 1));
            rx = DW'(8'hC0 + k);
            serve(g, tx, rx, 1);
        end
        req = '0;
        n   = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("rr_idle", 32'(busy), 32'(0));
        mon_en = 1'b0;

        // Watchdog abort: no finish edge at all
        req = 4'b0011;
        wait_grant();
        check("to_grant", 32'(grant), 32'(4'b0001));
        tick();
        check("to_start", 32'(start_master), 32'(1));
        n = 0;
        while (done == '0 && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 32'(17));
        check("to_done", 32'(done), 32'(4'b0001));
        check("to_err", 32'(err), 32'(1));
        check("to_rdata_kept", 32'(rdata), 32'(8'hC7));
        req = 4'b0010;
        tick();
        check("to_err_pulse", 32'(err), 32'(0));
        serve(4'b0010, 8'h22, 8'h9A, 1);
        req = '0;

        // finish_master already high before START is not a completion
        finish_master   = 1'b1;
        data_master_out = 8'hEE;
        req             = 4'b0100;
        wait_grant();
        check("stuck_grant", 32'(grant), 32'(4'b0100));
        tick();
        check("stuck_start", 32'(start_master), 32'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stuck_no_done", 32'(done), 32'(0));
        end
        finish_master = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("low_no_done", 32'(done), 32'(0));
        end
        finish_master   = 1'b1;
        data_master_out = 8'h5A;
        tick();
        check("stuck_done", 32'(done), 32'(4'b0100));
        check("stuck_rdata", 32'(rdata), 32'(8'h5A));
        check("stuck_err", 32'(err), 32'(0));
        finish_master = 1'b0;
        req           = '0;
        tick();

        // Reset while waiting for the master
        do_reset();
        req = 4'b0001;
        wait_grant();
        tick();
        tick();
        tick();
        check("wait_cs_low", 32'(cs_n), 32'(4'b1110));
        rst = 1'b1;
        tick();
        check("mid_rst_cs_n", 32'(cs_n), 32'(4'hF));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_grant", 32'(grant), 32'(0));
        rst = 1'b0;
        tick();
        check("post_rst_grant", 32'(grant), 32'(4'b0001));
        check("post_rst_cs_n", 32'(cs_n), 32'(4'b1110));
        check("post_rst_done", 32'(done), 32'(0));
        tick();
        check("post_rst_start", 32'(start_master), 32'(1));
        tick();
        finish_master   = 1'b1;
        data_master_out = 8'h77;
        tick();
        check("post_rst_txn_done", 32'(done), 32'(4'b0001));
        check("post_rst_rdata", 32'(rdata), 32'(8'h77));
        finish_master = 1'b0;
        req           = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
